spi_master_ctrl: RTL

Parametrised SPI master engine. Supersedes the fixed single-slave FSM with four additions: an internal SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first selection, and multiple chip selects. It also supports multi-word bursts that hold CS asserted between words, using a valid/ready TX handshake. It sits between the register/bus front-end and the SPI pads.

---
 rtl/spi_master_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master engine: programmable SCLK divider, CPOL/CPHA modes, bit order,
// multiple chip selects and multi-word bursts over a valid/ready TX handshake.
module spi_master_ctrl #(
    parameter int WORD_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done
);

    localparam int TGL  = 2 * WORD_W;
    localparam int TC_W = $clog2(TGL + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD, GAP} state_t;
    state_t state, state_nx;

    logic              cpol_l, cpha_l, lsb_l, last_l;
    logic [DIV_W-1:0]  div_l, cnt;
    logic [CS_W-1:0]   cs_l;
    logic [TC_W-1:0]   tcnt, tgl_k;
    logic [WORD_W-1:0] tx_sr, rx_sr;
    logic              accept, half_done, from_idle, cpha_e, lsb_e;
    logic              tgl, last_tgl, shift_now, sample_now;

    function automatic logic head(input logic [WORD_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[WORD_W-1];
    endfunction

    function automatic logic [WORD_W-1:0] drop(input logic [WORD_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[WORD_W-1:1]} : {w[WORD_W-2:0], 1'b0};
    endfunction

    function automatic logic [WORD_W-1:0] ins(input logic [WORD_W-1:0] w, input logic b,
                                              input logic lsb);
        return lsb ? {b, w[WORD_W-1:1]} : {w[WORD_W-2:0], b};
    endfunction

    assign accept     = tx_valid & tx_ready;
    assign half_done  = (cnt == '0);
    assign from_idle  = (state == IDLE);
    // The first accept of a frame must act on the live config, not the stale latch.
    assign cpha_e     = from_idle ? cpha : cpha_l;
    assign lsb_e      = from_idle ? lsb_first : lsb_l;
    assign tgl_k      = tcnt + TC_W'(1);
    assign tgl        = (state == XFER) && half_done;
    assign last_tgl   = tgl && (tgl_k == TC_W'(TGL));
    assign shift_now  = tgl && (tgl_k[0] == cpha_l) && !last_tgl;
    assign sample_now = tgl && (tgl_k[0] != cpha_l);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state != IDLE && !spi_en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)    state_nx = SETUP;
                SETUP:   if (half_done) state_nx = XFER;
                XFER:    if (last_tgl)  state_nx = last_l ? HOLD : WAIT;
                WAIT:    if (accept)    state_nx = SETUP;
                HOLD:    if (half_done) state_nx = GAP;
                GAP:     if (half_done) state_nx = IDLE;
                default:                state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        tx_ready = !rst && spi_en && (state == IDLE || state == WAIT);
        cs_n     = '1;
        // An out-of-range index shifts the bit out, leaving every select high.
        if (state inside {SETUP, XFER, WAIT, HOLD})
            cs_n = ~(NUM_CS'(1) << cs_l);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            last_l   <= 1'b0;
            div_l    <= '0;
            cs_l     <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            mosi     <= 1'b0;
            sclk     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (cnt != '0) cnt <= cnt - DIV_W'(1);
            else           cnt <= div_l;

            if (accept) begin
                if (from_idle) begin
                    cpol_l <= cpol;
                    cpha_l <= cpha;
                    lsb_l  <= lsb_first;
                    div_l  <= clk_div;
                    cs_l   <= cs_sel;
                    cnt    <= clk_div;
                    sclk   <= cpol;
                end else begin
                    cnt <= div_l;
                end
                last_l <= tx_last;
                tcnt   <= '0;
                if (!cpha_e) begin
                    mosi  <= head(tx_data, lsb_e);
                    tx_sr <= drop(tx_data, lsb_e);
                end else begin
                    tx_sr <= tx_data;
                end
            end else if (state_nx == IDLE) begin
                sclk <= cpol;
                mosi <= 1'b0;
                done <= (state == GAP) && spi_en;
            end else if (tgl) begin
                sclk <= ~sclk;
                tcnt <= tgl_k;
                if (shift_now) begin
                    mosi  <= head(tx_sr, lsb_l);
                    tx_sr <= drop(tx_sr, lsb_l);
                end
                if (sample_now) rx_sr <= ins(rx_sr, miso, lsb_l);
                if (last_tgl) begin
                    rx_valid <= 1'b1;
                    rx_data  <= cpha_l ? ins(rx_sr, miso, lsb_l) : rx_sr;
                end
            end
        end
    end

endmodule
